// File: rtl/reg_select_sequencer_if.sv
// Control-side bundle for reg_select_sequencer: IR, select/request inputs and the
// registered register-file strobes. The control unit is master, the sequencer slave.
interface reg_select_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int IR_W     = 32
);
    localparam int REG_W = $clog2(NUM_REGS);

    logic [IR_W-1:0]     ir;
    logic                gra;
    logic                grb;
    logic                grc;
    logic                rin;
    logic                rout;
    logic                baout;
    logic                start;
    logic                dir;
    logic                step;
    logic [NUM_REGS-1:0] rin_sig;
    logic [NUM_REGS-1:0] rout_sig;
    logic [REG_W-1:0]    cur_idx;
    logic                busy;
    logic                done;

    modport master (
        output ir, gra, grb, grc, rin, rout, baout, start, dir, step,
        input  rin_sig, rout_sig, cur_idx, busy, done
    );

    modport slave (
        input  ir, gra, grb, grc, rin, rout, baout, start, dir, step,
        output rin_sig, rout_sig, cur_idx, busy, done
    );
endinterface

// File: rtl/reg_select_sequencer.sv
// Register-select unit: single-select Ra/Rb/Rc decode plus a mask-walking block sequencer.
// Optional SEL_BAOUT_R0_EN makes R0 read as zero on baout and skips R0 in store sequences.
module reg_select_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int IR_W     = 32,
    parameter int RA_LSB   = 23,
    parameter int RB_LSB   = 19,
    parameter int RC_LSB   = 15,
    parameter int MASK_LSB = 0
) (
    input logic                   clk,
    input logic                   clr_n,
    reg_select_sequencer_if.slave bus
);
    localparam int REG_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {IDLE, SEQ, DONE} state_t;

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] mask_q, mask_d;
    logic                dir_q, dir_d;
    logic [NUM_REGS-1:0] rin_q, rin_d;
    logic [NUM_REGS-1:0] rout_q, rout_d;
    logic [REG_W-1:0]    idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [REG_W-1:0]    sel;
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] seq_mask;
    logic [NUM_REGS-1:0] seq_hot;
    logic                seq_go;

    function automatic logic [REG_W-1:0] lowest_idx(input logic [NUM_REGS-1:0] m);
        lowest_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = REG_W'(i);
        end
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d  = state_q;
        mask_d   = mask_q;
        dir_d    = dir_q;
        rin_d    = '0;
        rout_d   = '0;
        idx_d    = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        seq_mask = '0;
        seq_hot  = '0;
        seq_go   = 1'b0;

        sel = (bus.ir[RA_LSB +: REG_W] & {REG_W{bus.gra}})
            | (bus.ir[RB_LSB +: REG_W] & {REG_W{bus.grb}})
            | (bus.ir[RC_LSB +: REG_W] & {REG_W{bus.grc}});
        dec      = '0;
        dec[sel] = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    seq_mask = bus.ir[MASK_LSB +: NUM_REGS];
`ifdef SEL_BAOUT_R0_EN
                    // R0 is hard zero for stores, so it never earns a selection cycle.
                    if (!bus.dir) seq_mask[0] = 1'b0;
`endif
                    dir_d  = bus.dir;
                    seq_go = 1'b1;
                end else begin
                    rin_d = dec & {NUM_REGS{bus.rin}};
`ifdef SEL_BAOUT_R0_EN
                    rout_d = (bus.baout && sel == '0) ? '0
                           : dec & {NUM_REGS{bus.rout | bus.baout}};
`else
                    rout_d = dec & {NUM_REGS{bus.rout | bus.baout}};
`endif
                    idx_d = sel;
                end
            end
            SEQ: begin
                seq_mask = mask_q;
                if (bus.step) seq_mask[idx_q] = 1'b0;
                seq_go = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                mask_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        // Shared tail: pick the next register from the remaining mask, or finish.
        if (seq_go) begin
            mask_d = seq_mask;
            busy_d = 1'b1;
            if (seq_mask == '0) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d          = SEQ;
                idx_d            = lowest_idx(seq_mask);
                seq_hot[idx_d]   = 1'b1;
                if (dir_d) rin_d  = seq_hot;
                else       rout_d = seq_hot;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the async clear also wipes
    // the latched mask so no partial sequence survives a reset.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            dir_q   <= 1'b0;
            rin_q   <= '0;
            rout_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dir_q   <= dir_d;
            rin_q   <= rin_d;
            rout_q  <= rout_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.rin_sig  = rin_q;
    assign bus.rout_sig = rout_q;
    assign bus.cur_idx  = idx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_reg_select_sequencer.sv
// Self-checking bench for reg_select_sequencer: directed scenarios plus random traffic
// compared every cycle against a pending-register-list reference model.
module tb_reg_select_sequencer;
    localparam int N = 16;

    logic clk;
    logic clr_n;

    reg_select_sequencer_if #(.NUM_REGS(N), .IR_W(32)) bus ();

    reg_select_sequencer #(.NUM_REGS(N), .IR_W(32)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: registers still to visit, in visiting order.
    int       m_list[$];
    bit       m_dir;
    bit       m_in_done;
    bit [N-1:0] e_rin, e_rout;
    int       e_idx;
    bit       e_idx_ok, e_busy, e_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.ir = '0; bus.gra = 0; bus.grb = 0; bus.grc = 0;
        bus.rin = 0; bus.rout = 0; bus.baout = 0;
        bus.start = 0; bus.dir = 0; bus.step = 0;
    endtask

    task automatic model_reset();
        m_list.delete();
        m_in_done = 0;
        m_dir = 0;
        e_rin = '0; e_rout = '0; e_idx = 0; e_idx_ok = 1;
        e_busy = 0; e_done = 0;
    endtask

    task automatic expect_front();
        e_rin = '0; e_rout = '0; e_done = 0; e_busy = 1; e_idx_ok = 1;
        if (m_list.size() == 0) begin
            m_in_done = 1; e_done = 1; e_idx_ok = 0;
        end else begin
            e_idx = m_list[0];
            if (m_dir) e_rin[e_idx] = 1'b1;
            else       e_rout[e_idx] = 1'b1;
        end
    endtask

    task automatic model_step();
        int ra, rb, rc, sel;
        if (m_in_done) begin
            m_in_done = 0;
            e_rin = '0; e_rout = '0; e_busy = 0; e_done = 0; e_idx_ok = 0;
        end else if (m_list.size() > 0) begin
            if (bus.step) void'(m_list.pop_front());
            expect_front();
        end else if (bus.start) begin
            m_dir = bus.dir;
            for (int i = 0; i < N; i++) begin
                if (bus.ir[i]) begin
`ifdef SEL_BAOUT_R0_EN
                    if (!(i == 0 && !m_dir)) m_list.push_back(i);
`else
                    m_list.push_back(i);
`endif
                end
            end
            expect_front();
        end else begin
            ra  = int'(bus.ir[26:23]);
            rb  = int'(bus.ir[22:19]);
            rc  = int'(bus.ir[18:15]);
            sel = (bus.gra ? ra : 0) | (bus.grb ? rb : 0) | (bus.grc ? rc : 0);
            e_rin = '0; e_rout = '0;
            if (bus.rin) e_rin[sel] = 1'b1;
            if (bus.rout || bus.baout) e_rout[sel] = 1'b1;
`ifdef SEL_BAOUT_R0_EN
            if (bus.baout && sel == 0) e_rout = '0;
`endif
            e_idx = sel; e_idx_ok = 1; e_busy = 0; e_done = 0;
        end
    endtask

    task automatic compare();
        check("rin_sig", 32'(bus.rin_sig), 32'(e_rin));
        check("rout_sig", 32'(bus.rout_sig), 32'(e_rout));
        check("busy", 32'(bus.busy), 32'(e_busy));
        check("done", 32'(bus.done), 32'(e_done));
        if (e_idx_ok) check("cur_idx", 32'(bus.cur_idx), 32'(e_idx));
    endtask

    // Inputs are set at the falling edge; the DUT samples them on the next rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
        @(negedge clk);
    endtask

    initial begin
        clr_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_rin", 32'(bus.rin_sig), 32'h0);
        check("reset_rout", 32'(bus.rout_sig), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        clr_n = 1'b1;

        // Single select via Ra.
        bus.ir = 32'(5) << 23; bus.gra = 1; bus.rin = 1;
        tick();
        check("single_rin", 32'(bus.rin_sig), 32'h0020);
        check("single_idx", 32'(bus.cur_idx), 32'd5);
        clear_inputs();

        // Store sequence with step held high.
        bus.ir = 32'h8012; bus.dir = 0; bus.start = 1; bus.step = 1;
        tick();
        check("store_0", 32'(bus.rout_sig), 32'h0002);
        bus.start = 0;
        tick();
        check("store_1", 32'(bus.rout_sig), 32'h0010);
        tick();
        check("store_2", 32'(bus.rout_sig), 32'h8000);
        tick();
        check("store_done", 32'(bus.done), 32'h1);
        clear_inputs();
        tick();

        // Stalled load.
        bus.ir = 32'h0009; bus.dir = 1; bus.start = 1;
        tick();
        bus.start = 0;
        repeat (3) tick();
        check("stall_hold", 32'(bus.rin_sig), 32'h0001);
        bus.step = 1;
        tick();
        check("stall_next", 32'(bus.rin_sig), 32'h0008);
        tick();
        check("stall_done", 32'(bus.done), 32'h1);
        clear_inputs();
        tick();

        // Empty mask, then a start while busy that must be ignored.
        bus.start = 1; bus.ir = '0;
        tick();
        check("empty_done", 32'(bus.done), 32'h1);
        bus.start = 0;
        tick();
        bus.ir = 32'h0006; bus.dir = 1; bus.start = 1;
        tick();
        bus.ir = 32'hFFFF; bus.dir = 0;
        tick();
        bus.start = 0; bus.step = 1;
        repeat (3) tick();
        clear_inputs();
        tick();

        // Asynchronous reset during the second of three selections.
        bus.ir = 32'h0054; bus.dir = 1; bus.start = 1; bus.step = 1;
        tick();
        bus.start = 0;
        tick();
        #2 clr_n = 1'b0;
        #1;
        check("midrst_rin", 32'(bus.rin_sig), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        model_reset();
        @(negedge clk);
        clr_n = 1'b1;
        clear_inputs();
        bus.ir = 32'h0300; bus.dir = 1; bus.start = 1; bus.step = 1;
        tick();
        check("after_rst", 32'(bus.rin_sig), 32'h0100);
        bus.start = 0;
        repeat (3) tick();
        clear_inputs();

        // R0 handling on baout and in store sequences.
        bus.gra = 1; bus.baout = 1;
        tick();
`ifdef SEL_BAOUT_R0_EN
        check("r0_baout", 32'(bus.rout_sig), 32'h0000);
`else
        check("r0_baout", 32'(bus.rout_sig), 32'h0001);
`endif
        clear_inputs();
        bus.ir = 32'h0003; bus.dir = 0; bus.start = 1; bus.step = 1;
        tick();
        bus.start = 0;
`ifdef SEL_BAOUT_R0_EN
        check("r0_seq_0", 32'(bus.rout_sig), 32'h0002);
        tick();
        check("r0_seq_done", 32'(bus.done), 32'h1);
`else
        check("r0_seq_0", 32'(bus.rout_sig), 32'h0001);
        tick();
        check("r0_seq_1", 32'(bus.rout_sig), 32'h0002);
        tick();
        check("r0_seq_done", 32'(bus.done), 32'h1);
`endif
        clear_inputs();
        tick();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] word;
            word = $urandom;
            case ($urandom_range(0, 3))
                0:       word[15:0] = '0;
                1:       word[15:0] = word[15:0] & 16'($urandom) & 16'($urandom);
                default: ;
            endcase
            bus.ir    = word;
            bus.gra   = 1'($urandom_range(0, 1));
            bus.grb   = 1'($urandom_range(0, 3) == 0);
            bus.grc   = 1'($urandom_range(0, 3) == 0);
            bus.rin   = 1'($urandom_range(0, 1));
            bus.rout  = 1'($urandom_range(0, 1));
            bus.baout = 1'($urandom_range(0, 2) == 0);
            bus.start = 1'($urandom_range(0, 5) == 0);
            bus.dir   = 1'($urandom_range(0, 1));
            bus.step  = 1'($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reg_select_sequencer.md
# reg_select_sequencer

Parametrised register-select unit for the datapath register file. It decodes the Ra/Rb/Rc fields of the instruction register into registered one-hot `rin_sig`/`rout_sig` strobes, as the single-select path does today. It adds a multi-register sequencing mode that walks a register mask from the IR one register per step, for block load/store micro-sequences. It sits between the control unit and the register-file enables.

## Interface
Parameters:
- `NUM_REGS`, 16: register count; power of two, 2..32. `REG_W = $clog2(NUM_REGS)` is derived.
- `IR_W`, 32: instruction register width.
- `RA_LSB`, 23: LSB of the Ra field (`REG_W` bits).
- `RB_LSB`, 19: LSB of the Rb field.
- `RC_LSB`, 15: LSB of the Rc field.
- `MASK_LSB`, 0: LSB of the register mask, `ir[MASK_LSB +: NUM_REGS]`.

Ports:
- Clock and reset: one clock, `clk`; reset `clr_n` is asynchronous and active-low.
- `clk`  in  1  clock.
- `clr_n`  in  1  asynchronous active-low reset.
- `ir`  in  `IR_W`  instruction register.
- `gra`, `grb`, `grc`  in  1 each  field selects for the single-select path.
- `rin`, `rout`, `baout`  in  1 each  register write, read and base-address-read requests.
- `start`  in  1  begins a mask sequence (sampled in IDLE only).
- `dir`  in  1  sequence direction, latched at `start`: 1 = load (drive `rin_sig`), 0 = store (drive `rout_sig`).
- `step`  in  1  control has consumed the current register; advance.
- `rin_sig`  out  `NUM_REGS`  one-hot register write enable.
- `rout_sig`  out  `NUM_REGS`  one-hot register output enable.
- `cur_idx`  out  `REG_W`  index of the register currently selected by the sequence.
- `busy`  out  1  high in SEQ and DONE.
- `done`  out  1  one-cycle pulse at sequence end.

## Operation
- FSM states: IDLE, SEQ, DONE. On reset: state = IDLE; all outputs = 0; mask register = 0.
- IDLE without `start` (single-select path):
  - `sel = (ra & {gra}) | (rb & {grb}) | (rc & {grc})`, i.e. field values ORed.
  - `dec = 1 << sel`.
  - Next cycle: `rin_sig = dec & {rin}`, `rout_sig = dec & {rout | baout}` (see Configuration).
  - `cur_idx = sel`.
- IDLE with `start`:
  - Latch `mask = ir[MASK_LSB +: NUM_REGS]` and latch `dir`.
  - Single-select outputs are forced to 0 on that edge; `start` wins over the single-select path.
  - If `mask == 0`: go to DONE. Otherwise go to SEQ.
- SEQ:
  - `cur_idx` = lowest set bit of `mask`.
  - The one-hot of `cur_idx` drives `rin_sig` if `dir = 1`, else `rout_sig`; the other output is 0.
  - The selection holds while `step = 0`.
  - On `step = 1`: clear bit `cur_idx` in `mask`. If the remaining mask is 0, go to DONE; else select the next lowest set bit on the next cycle.
- DONE: `done = 1` for one cycle; `rin_sig = rout_sig = 0`; return to IDLE.
- While `busy`: `start`, the `gr*` inputs, `rin`, `rout`, `baout` and `ir` are ignored.
- `clr_n` low at any point, including mid-sequence, returns to IDLE immediately with all outputs 0. No partial-sequence state survives.
- `rin_sig` and `rout_sig` are never both nonzero in SEQ. Each is at most one-hot in every state.

## Timing
- All outputs are registered. Single-select latency is 1 cycle: inputs sampled at edge N appear after edge N.
- Sequence latency:
  - `start` at edge k puts the first register on the bus after edge k.
  - With `step` held high, an n-bit mask gives n consecutive selection cycles, then one `done` cycle.
  - `busy` is high from edge k to the end of the `done` cycle.
- Empty mask: `start` at edge k puts `done` high after edge k. No strobes are asserted.
- A `step` in the last SEQ cycle sets `done` high on the next cycle. `step` in IDLE or DONE has no effect.
- Back-to-back sequences: `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- `SEL_BAOUT_R0_EN` defined:
  - If `baout = 1` and `sel == 0`, `rout_sig` is all zeros, so R0 reads as constant zero for base-address arithmetic.
  - `baout` with `sel != 0` behaves like `rout`.
  - In SEQ with `dir = 0`, R0 in the mask is skipped: its bit is cleared without a selection cycle.
- Not defined: `baout` is a plain alias for `rout`, and R0 is treated like any other register.

## Test plan
- Single select: `NUM_REGS=16`, `ir[26:23]=5`, `gra=1`, `rin=1` -> after one edge `rin_sig=16'h0020`, `rout_sig=0`, `cur_idx=5`.
- Store sequence: `ir[15:0]=16'h8012`, `dir=0`, `start`, `step` held 1 -> `rout_sig` is `0x0002`, `0x0010`, `0x8000` on consecutive cycles, then `done=1`, `busy` high for 4 cycles.
- Stalled load: `mask=16'h0009`, `dir=1`, `step=0` for 3 cycles then 1 -> `rin_sig=0x0001` held for 4 cycles, then `0x0008`, then `done`.
- Empty mask and start-during-busy: `mask=0` -> `done` on the cycle after `start`, no strobes. A second `start` while `busy` is ignored; `mask` is unchanged.
- Reset mid-sequence: assert `clr_n=0` asynchronously during the second of three selections -> all outputs 0 at once. After release, state is IDLE and a new `start` begins from the new mask.
- `SEL_BAOUT_R0_EN`: `ir` Ra=0, `gra=1`, `baout=1` -> `rout_sig=0`. Sequence with `mask=16'h0003`, `dir=0` -> only `0x0002`, then `done`. Without the macro the same stimuli give `0x0001`, and `0x0001` then `0x0002`.
